// File: rtl/bp_fe_cmd_sequencer.sv
// FE command sequencer: decodes BE->FE commands, runs the fetch FSM, buffers attaboys and
// serialises fetch bundles into fe_queue. Define BP_FE_SEQ_PERF_EN to add saturating perf counters.
module bp_fe_cmd_sequencer #(
  parameter int vaddr_width_p = 39,
  parameter int fetch_width_p = 2,
  parameter int attaboy_els_p = 4,
  parameter int perf_width_p  = 16,
  localparam int cnt_w = $clog2(fetch_width_p + 1),
  localparam int ptr_w = $clog2(attaboy_els_p)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         init_done_i,
  input  logic                         cmd_v_i,
  input  logic [2:0]                   cmd_opcode_i,
  input  logic [vaddr_width_p-1:0]     cmd_npc_i,
  input  logic                         cmd_taken_i,
  output logic                         cmd_yumi_o,
  output logic                         redirect_v_o,
  output logic [vaddr_width_p-1:0]     redirect_pc_o,
  output logic                         icache_fence_o,
  output logic                         itlb_w_v_o,
  output logic                         itlb_fence_v_o,
  output logic                         attaboy_v_o,
  output logic [vaddr_width_p-1:0]     attaboy_pc_o,
  output logic                         attaboy_taken_o,
  input  logic                         attaboy_yumi_i,
  output logic                         icache_v_o,
  input  logic                         icache_yumi_i,
  input  logic                         fetch_v_i,
  input  logic [vaddr_width_p-1:0]     fetch_pc_i,
  input  logic [32*fetch_width_p-1:0]  fetch_instr_i,
  input  logic [cnt_w-1:0]             fetch_cnt_i,
  output logic                         fetch_ready_and_o,
  output logic                         fe_queue_v_o,
  output logic [vaddr_width_p-1:0]     fe_queue_pc_o,
  output logic [31:0]                  fe_queue_instr_o,
  input  logic                         fe_queue_ready_and_i,
  output logic [1:0]                   state_o
`ifdef BP_FE_SEQ_PERF_EN
  ,
  output logic [perf_width_p-1:0]      perf_redirect_o,
  output logic [perf_width_p-1:0]      perf_attaboy_stall_o,
  output logic [perf_width_p-1:0]      perf_drop_o
`endif
);

  if (fetch_width_p < 1) begin : g_bad_fetch_width
    $error("fetch_width_p must be >= 1");
  end
  if (attaboy_els_p < 2 || (attaboy_els_p & (attaboy_els_p - 1)) != 0) begin : g_bad_attaboy_els
    $error("attaboy_els_p must be a power of 2 >= 2");
  end
  if (perf_width_p < 1) begin : g_bad_perf_width
    $error("perf_width_p must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESUME = 2'd3
  } state_e;

  state_e state_r, state_n;

  function automatic logic [vaddr_width_p-1:0] instr_pc(input logic [vaddr_width_p-1:0] base,
                                                        input logic [cnt_w-1:0] idx);
    return base + vaddr_width_p'({idx, 2'b00});
  endfunction

  logic is_attaboy, is_complex;
  logic ab_push, ab_pop, ab_full, ab_empty;
  logic [ptr_w:0] ab_wr_ptr, ab_rd_ptr;
  logic [vaddr_width_p-1:0] ab_pc_mem [attaboy_els_p];
  logic                     ab_taken_mem [attaboy_els_p];

  logic                         vld_p1;
  logic [vaddr_width_p-1:0]     pc_p1;
  logic [32*fetch_width_p-1:0]  instr_p1;
  logic [cnt_w-1:0]             cnt_p1, idx_p1;
  logic fq_hs, last_p1, fetch_accept;

  assign is_attaboy = (cmd_opcode_i == 3'd6);
  assign is_complex = (cmd_opcode_i == 3'd5) || (cmd_opcode_i == 3'd7);

  // Command decode; strobes fire only in the cycle the command is consumed.
  always_comb begin
    cmd_yumi_o     = 1'b0;
    redirect_v_o   = 1'b0;
    icache_fence_o = 1'b0;
    itlb_w_v_o     = 1'b0;
    itlb_fence_v_o = 1'b0;
    ab_push        = 1'b0;
    state_n        = state_r;
    if (cmd_v_i) begin
      if (state_r == ST_RESET) begin
        if (cmd_opcode_i == 3'd0) begin
          if (init_done_i) begin
            cmd_yumi_o   = 1'b1;
            redirect_v_o = 1'b1;
            state_n      = ST_RESUME;
          end
        end else if (!is_attaboy) begin
          cmd_yumi_o = 1'b1;
        end
      end else if (is_attaboy) begin
        ab_push    = ~ab_full;
        cmd_yumi_o = ~ab_full;
      end else if (cmd_opcode_i != 3'd0 || init_done_i) begin
        cmd_yumi_o     = 1'b1;
        redirect_v_o   = 1'b1;
        icache_fence_o = (cmd_opcode_i == 3'd4);
        itlb_fence_v_o = (cmd_opcode_i == 3'd5);
        itlb_w_v_o     = (cmd_opcode_i == 3'd7);
        if (cmd_opcode_i == 3'd3 || cmd_opcode_i == 3'd4)
          state_n = ST_WAIT;
        else if (is_complex || cmd_opcode_i == 3'd0)
          state_n = ST_RESUME;
        else
          state_n = ST_RUN;
      end
    end
    if (!redirect_v_o && state_r == ST_RESUME && icache_yumi_i)
      state_n = ST_RUN;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= ST_RESET;
    else         state_r <= state_n;
  end

  assign state_o       = state_r;
  assign redirect_pc_o = cmd_npc_i;
  assign icache_v_o    = ((state_r == ST_RUN) && !(cmd_v_i && is_complex)) || (state_r == ST_RESUME);

  // Attaboy FIFO: pointers carry a wrap bit; a full FIFO refuses pushes even when popping.
  assign ab_empty = (ab_wr_ptr == ab_rd_ptr);
  assign ab_full  = (ab_wr_ptr[ptr_w] != ab_rd_ptr[ptr_w]) &&
                    (ab_wr_ptr[ptr_w-1:0] == ab_rd_ptr[ptr_w-1:0]);
  assign ab_pop   = attaboy_yumi_i & ~ab_empty;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ab_wr_ptr <= '0;
      ab_rd_ptr <= '0;
    end else begin
      if (ab_push) ab_wr_ptr <= ab_wr_ptr + 1'b1;
      if (ab_pop)  ab_rd_ptr <= ab_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ab_push) begin
      ab_pc_mem[ab_wr_ptr[ptr_w-1:0]]    <= cmd_npc_i;
      ab_taken_mem[ab_wr_ptr[ptr_w-1:0]] <= cmd_taken_i;
    end
  end

  assign attaboy_v_o     = ~ab_empty;
  assign attaboy_pc_o    = ab_pc_mem[ab_rd_ptr[ptr_w-1:0]];
  assign attaboy_taken_o = ab_taken_mem[ab_rd_ptr[ptr_w-1:0]];

  // Stage p1: accepted bundle, drained one instruction per fe_queue handshake.
  assign fe_queue_v_o      = vld_p1 & ~redirect_v_o;
  assign fq_hs             = fe_queue_v_o & fe_queue_ready_and_i;
  assign last_p1           = (idx_p1 == cnt_p1 - cnt_w'(1));
  assign fetch_ready_and_o = (state_r == ST_RUN) && !redirect_v_o && (!vld_p1 || (fq_hs && last_p1));
  assign fetch_accept      = fetch_v_i & fetch_ready_and_o;
  assign fe_queue_pc_o     = instr_pc(pc_p1, idx_p1);
  assign fe_queue_instr_o  = instr_p1[32*idx_p1 +: 32];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
    end else if (redirect_v_o) begin
      vld_p1 <= 1'b0;
    end else if (fetch_accept) begin
      vld_p1 <= (fetch_cnt_i != '0);
      idx_p1 <= '0;
    end else if (fq_hs) begin
      if (last_p1) vld_p1 <= 1'b0;
      else         idx_p1 <= idx_p1 + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fetch_accept) begin
      pc_p1    <= fetch_pc_i;
      instr_p1 <= fetch_instr_i;
      cnt_p1   <= fetch_cnt_i;
    end
  end

`ifdef BP_FE_SEQ_PERF_EN
  function automatic logic [perf_width_p-1:0] sat_add(input logic [perf_width_p-1:0] a,
                                                      input logic [perf_width_p-1:0] b);
    logic [perf_width_p:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[perf_width_p] ? {perf_width_p{1'b1}} : s[perf_width_p-1:0];
  endfunction

  logic ab_stall;
  assign ab_stall = cmd_v_i & is_attaboy & (state_r != ST_RESET) & ab_full;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_redirect_o      <= '0;
      perf_attaboy_stall_o <= '0;
      perf_drop_o          <= '0;
    end else begin
      if (redirect_v_o)
        perf_redirect_o <= sat_add(perf_redirect_o, perf_width_p'(1));
      if (ab_stall)
        perf_attaboy_stall_o <= sat_add(perf_attaboy_stall_o, perf_width_p'(1));
      if (redirect_v_o && vld_p1)
        perf_drop_o <= sat_add(perf_drop_o, perf_width_p'(cnt_p1 - idx_p1));
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_cmd_sequencer.sv
// Directed bench for bp_fe_cmd_sequencer: a per-cycle vector table plus hand-written
// sequences for redirect-mid-bundle, attaboy FIFO back-pressure, itlb fill/resume and reset.
module tb_bp_fe_cmd_sequencer;
  localparam int VA = 39;
  localparam int FW = 2;
  localparam int CW = $clog2(FW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, init_done_i, cmd_v_i, cmd_taken_i, attaboy_yumi_i, icache_yumi_i;
  logic fetch_v_i, fe_queue_ready_and_i;
  logic [2:0] cmd_opcode_i;
  logic [VA-1:0] cmd_npc_i, fetch_pc_i;
  logic [32*FW-1:0] fetch_instr_i;
  logic [CW-1:0] fetch_cnt_i;
  logic cmd_yumi_o, redirect_v_o, icache_fence_o, itlb_w_v_o, itlb_fence_v_o;
  logic attaboy_v_o, attaboy_taken_o, icache_v_o, fetch_ready_and_o, fe_queue_v_o;
  logic [VA-1:0] redirect_pc_o, attaboy_pc_o, fe_queue_pc_o;
  logic [31:0] fe_queue_instr_o;
  logic [1:0] state_o;

  bp_fe_cmd_sequencer #(.vaddr_width_p(VA), .fetch_width_p(FW), .attaboy_els_p(4), .perf_width_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_i(init_done_i),
    .cmd_v_i(cmd_v_i), .cmd_opcode_i(cmd_opcode_i), .cmd_npc_i(cmd_npc_i), .cmd_taken_i(cmd_taken_i),
    .cmd_yumi_o(cmd_yumi_o), .redirect_v_o(redirect_v_o), .redirect_pc_o(redirect_pc_o),
    .icache_fence_o(icache_fence_o), .itlb_w_v_o(itlb_w_v_o), .itlb_fence_v_o(itlb_fence_v_o),
    .attaboy_v_o(attaboy_v_o), .attaboy_pc_o(attaboy_pc_o), .attaboy_taken_o(attaboy_taken_o),
    .attaboy_yumi_i(attaboy_yumi_i), .icache_v_o(icache_v_o), .icache_yumi_i(icache_yumi_i),
    .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i),
    .fetch_cnt_i(fetch_cnt_i), .fetch_ready_and_o(fetch_ready_and_o),
    .fe_queue_v_o(fe_queue_v_o), .fe_queue_pc_o(fe_queue_pc_o), .fe_queue_instr_o(fe_queue_instr_o),
    .fe_queue_ready_and_i(fe_queue_ready_and_i), .state_o(state_o)
  );

  typedef struct {
    logic           cv;
    logic [2:0]     op;
    logic [VA-1:0]  npc;
    logic           idone;
    logic           iy;
    logic           fv;
    logic [VA-1:0]  fpc;
    logic [CW-1:0]  fcnt;
    logic [63:0]    fins;
    logic           fqr;
    logic           e_yumi;
    logic           e_redir;
    logic           e_icv;
    logic           e_fqv;
    logic [VA-1:0]  e_fqpc;
    logic [31:0]    e_ins;
    logic [1:0]     e_state;
    logic           e_frdy;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs [21];

  function automatic vec_t mk(logic cv, logic [2:0] op, logic [VA-1:0] npc, logic idone, logic iy,
                              logic fv, logic [VA-1:0] fpc, logic [CW-1:0] fcnt, logic [63:0] fins,
                              logic fqr, logic e_yumi, logic e_redir, logic e_icv, logic e_fqv,
                              logic [VA-1:0] e_fqpc, logic [31:0] e_ins, logic [1:0] e_state,
                              logic e_frdy);
    vec_t v;
    v.cv = cv; v.op = op; v.npc = npc; v.idone = idone; v.iy = iy; v.fv = fv; v.fpc = fpc;
    v.fcnt = fcnt; v.fins = fins; v.fqr = fqr; v.e_yumi = e_yumi; v.e_redir = e_redir;
    v.e_icv = e_icv; v.e_fqv = e_fqv; v.e_fqpc = e_fqpc; v.e_ins = e_ins; v.e_state = e_state;
    v.e_frdy = e_frdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    cmd_v_i = 0; cmd_opcode_i = 0; cmd_npc_i = '0; cmd_taken_i = 0; init_done_i = 1;
    icache_yumi_i = 0; attaboy_yumi_i = 0; fetch_v_i = 0; fetch_pc_i = '0; fetch_instr_i = '0;
    fetch_cnt_i = '0; fe_queue_ready_and_i = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [VA-1:0] npc);
    cmd_v_i = 1; cmd_opcode_i = op; cmd_npc_i = npc;
  endtask

  initial begin
    vecs[0]  = mk(1,0,39'h1000,0,0, 0,'0,0,64'h0,1, 0,0,0,0,'0,0,2'd0,0);
    vecs[1]  = mk(1,0,39'h1000,0,0, 0,'0,0,64'h0,1, 0,0,0,0,'0,0,2'd0,0);
    vecs[2]  = mk(1,0,39'h1000,0,0, 0,'0,0,64'h0,1, 0,0,0,0,'0,0,2'd0,0);
    vecs[3]  = mk(1,0,39'h1000,1,0, 0,'0,0,64'h0,1, 1,1,0,0,'0,0,2'd0,0);
    vecs[4]  = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,1,0,'0,0,2'd3,0);
    vecs[5]  = mk(0,0,'0,1,1, 0,'0,0,64'h0,1, 0,0,1,0,'0,0,2'd3,0);
    vecs[6]  = mk(0,0,'0,1,0, 1,39'h1000,2,64'h0000_0B0B_0000_0A0A,1, 0,0,1,0,'0,0,2'd2,1);
    vecs[7]  = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,1,1,39'h1000,32'h0A0A,2'd2,0);
    vecs[8]  = mk(0,0,'0,1,0, 1,39'h7F_FFFF_FFFC,2,64'h0000_0D0D_0000_0C0C,1, 0,0,1,1,39'h1004,32'h0B0B,2'd2,1);
    vecs[9]  = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,1,1,39'h7F_FFFF_FFFC,32'h0C0C,2'd2,0);
    vecs[10] = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,1,1,39'h0,32'h0D0D,2'd2,1);
    vecs[11] = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,1,0,'0,0,2'd2,1);
    vecs[12] = mk(0,0,'0,1,0, 1,39'h3000,1,64'h0000_0F0F_0000_0E0E,0, 0,0,1,0,'0,0,2'd2,1);
    vecs[13] = mk(0,0,'0,1,0, 0,'0,0,64'h0,0, 0,0,1,1,39'h3000,32'h0E0E,2'd2,0);
    vecs[14] = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,1,1,39'h3000,32'h0E0E,2'd2,1);
    vecs[15] = mk(0,0,'0,1,0, 1,39'h5000,0,64'h0,1, 0,0,1,0,'0,0,2'd2,1);
    vecs[16] = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,1,0,'0,0,2'd2,1);
    vecs[17] = mk(1,3,39'h4000,1,0, 0,'0,0,64'h0,1, 1,1,1,0,'0,0,2'd2,0);
    vecs[18] = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,0,0,'0,0,2'd1,0);
    vecs[19] = mk(1,1,39'h6000,1,0, 0,'0,0,64'h0,1, 1,1,0,0,'0,0,2'd1,0);
    vecs[20] = mk(0,0,'0,1,0, 0,'0,0,64'h0,1, 0,0,1,0,'0,0,2'd2,1);

    idle();
    reset_i = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_state", state_o, 0);
    chk("reset_fq_v", fe_queue_v_o, 0);
    chk("reset_ab_v", attaboy_v_o, 0);
    chk("reset_icache_v", icache_v_o, 0);
    next_cycle();
    reset_i = 0;

    for (int i = 0; i < 21; i++) begin
      cmd_v_i = vecs[i].cv; cmd_opcode_i = vecs[i].op; cmd_npc_i = vecs[i].npc;
      init_done_i = vecs[i].idone; icache_yumi_i = vecs[i].iy; fetch_v_i = vecs[i].fv;
      fetch_pc_i = vecs[i].fpc; fetch_cnt_i = vecs[i].fcnt; fetch_instr_i = vecs[i].fins;
      fe_queue_ready_and_i = vecs[i].fqr;
      @(negedge clk);
      chk($sformatf("v%0d_yumi", i), cmd_yumi_o, vecs[i].e_yumi);
      chk($sformatf("v%0d_redirect", i), redirect_v_o, vecs[i].e_redir);
      if (vecs[i].e_redir) chk($sformatf("v%0d_redirect_pc", i), redirect_pc_o, vecs[i].npc);
      chk($sformatf("v%0d_icache_v", i), icache_v_o, vecs[i].e_icv);
      chk($sformatf("v%0d_fq_v", i), fe_queue_v_o, vecs[i].e_fqv);
      if (vecs[i].e_fqv) begin
        chk($sformatf("v%0d_fq_pc", i), fe_queue_pc_o, vecs[i].e_fqpc);
        chk($sformatf("v%0d_fq_instr", i), fe_queue_instr_o, vecs[i].e_ins);
      end
      chk($sformatf("v%0d_state", i), state_o, vecs[i].e_state);
      chk($sformatf("v%0d_fetch_rdy", i), fetch_ready_and_o, vecs[i].e_frdy);
      next_cycle();
    end

    // Redirect after the first pop of a two-instruction bundle.
    idle();
    fetch_v_i = 1; fetch_pc_i = 39'h1000; fetch_cnt_i = 2; fetch_instr_i = 64'h2222_0000_1111_0000;
    next_cycle();
    idle();
    @(negedge clk);
    chk("rd_first_v", fe_queue_v_o, 1);
    chk("rd_first_pc", fe_queue_pc_o, 39'h1000);
    next_cycle();
    cmd(3'd1, 39'h2000);
    @(negedge clk);
    chk("rd_redirect_v", redirect_v_o, 1);
    chk("rd_redirect_pc", redirect_pc_o, 39'h2000);
    chk("rd_fq_forced_low", fe_queue_v_o, 0);
    next_cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rd_dropped_never_emitted", fe_queue_v_o, 0);
      next_cycle();
    end

    // Attaboy FIFO fill, stall, pop-while-full, survival across a redirect.
    for (int k = 1; k <= 4; k++) begin
      cmd(3'd6, VA'(k * 16)); cmd_taken_i = k[0];
      @(negedge clk);
      chk($sformatf("ab%0d_yumi", k), cmd_yumi_o, 1);
      chk($sformatf("ab%0d_no_redirect", k), redirect_v_o, 0);
      next_cycle();
    end
    cmd(3'd6, 39'h50); cmd_taken_i = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("ab5_stall", cmd_yumi_o, 0);
      next_cycle();
    end
    attaboy_yumi_i = 1;
    @(negedge clk);
    chk("ab_head_pc", attaboy_pc_o, 39'h10);
    chk("ab_head_taken", attaboy_taken_o, 1);
    chk("ab5_full_blocks_while_pop", cmd_yumi_o, 0);
    next_cycle();
    attaboy_yumi_i = 0;
    @(negedge clk);
    chk("ab5_enq_after_pop", cmd_yumi_o, 1);
    next_cycle();
    idle();
    cmd(3'd1, 39'h9000);
    @(negedge clk);
    chk("ab_redirect_yumi", cmd_yumi_o, 1);
    next_cycle();
    idle();
    attaboy_yumi_i = 1;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("ab_pop%0d_v", k), attaboy_v_o, 1);
      chk($sformatf("ab_pop%0d_pc", k), attaboy_pc_o, 64'(k * 16));
      chk($sformatf("ab_pop%0d_taken", k), attaboy_taken_o, k[0]);
      next_cycle();
    end
    @(negedge clk);
    chk("ab_empty", attaboy_v_o, 0);
    next_cycle();

    // icache fence -> wait, redirect -> run, itlb fill -> resume until icache_yumi_i.
    idle();
    cmd(3'd4, 39'hA000);
    @(negedge clk);
    chk("fence_strobe", icache_fence_o, 1);
    next_cycle();
    cmd(3'd1, 39'hB000);
    @(negedge clk);
    chk("fence_state_wait", state_o, 1);
    chk("fence_strobe_gone", icache_fence_o, 0);
    next_cycle();
    cmd(3'd7, 39'h8000);
    @(negedge clk);
    chk("itlb_state_run", state_o, 2);
    chk("itlb_w_strobe", itlb_w_v_o, 1);
    chk("itlb_yumi", cmd_yumi_o, 1);
    chk("itlb_icache_v_low", icache_v_o, 0);
    next_cycle();
    idle();
    icache_yumi_i = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("itlb_w_one_cycle", itlb_w_v_o, 0);
      chk("itlb_state_resume", state_o, 3);
      chk("itlb_icache_v_held", icache_v_o, 1);
      next_cycle();
    end
    icache_yumi_i = 1;
    next_cycle();
    idle();
    @(negedge clk);
    chk("resume_to_run", state_o, 2);
    next_cycle();

    // Reset in the middle of a bundle with an attaboy queued.
    fetch_v_i = 1; fetch_pc_i = 39'h1000; fetch_cnt_i = 2; fe_queue_ready_and_i = 0;
    next_cycle();
    idle();
    fe_queue_ready_and_i = 0;
    cmd(3'd6, 39'h77);
    @(negedge clk);
    chk("mid_fq_v", fe_queue_v_o, 1);
    chk("mid_ab_yumi", cmd_yumi_o, 1);
    next_cycle();
    idle();
    reset_i = 1;
    next_cycle();
    reset_i = 0;
    @(negedge clk);
    chk("mid_reset_state", state_o, 0);
    chk("mid_reset_fq_v", fe_queue_v_o, 0);
    chk("mid_reset_ab_v", attaboy_v_o, 0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
